// File: rtl/acc_result_reader.sv
// Result-matrix read responder: captures C on acc_done and serves it as 32-bit
// words on a req/gnt/rvalid port, alongside a status word (READY, ovr, wcnt).
module acc_result_reader #(
  parameter int unsigned N_BYTES     = 1024,
  parameter int unsigned BASE_ADDR   = 3072,
  parameter int unsigned STATUS_ADDR = 1020
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acc_done,
  input  logic [N_BYTES*8-1:0] acc_in,
  input  logic                 req_i,
  input  logic [31:0]          addr_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o
);
  localparam int unsigned N_WORDS = N_BYTES / 4;
  localparam int unsigned IDX_W   = $clog2(N_WORDS);
  localparam int unsigned WCNT_W  = IDX_W + 1;
  localparam logic [31:0] C_LO    = 32'(BASE_ADDR);
  localparam logic [31:0] C_HI    = 32'(BASE_ADDR + N_BYTES);
  localparam logic [31:0] C_LAST  = 32'(BASE_ADDR + N_BYTES - 4);
  localparam logic [31:0] ST_ADDR = 32'(STATUS_ADDR);
  localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(N_WORDS);

  typedef enum logic {EMPTY = 1'b0, READY = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                ovr_q, ovr_d;
  logic [N_BYTES*8-1:0] buf_q;
  rsp_t                rsp_q, rsp_d;
  logic                vld_q;

  logic [31:0]      addr_w, off;
  logic [IDX_W-1:0] widx;
  logic             in_c, is_st, last_rd, ready;
  logic [31:0]      status;

  assign gnt_o  = req_i;
  assign addr_w = {addr_i[31:2], 2'b00};
  assign off    = addr_w - C_LO;
  assign widx   = off[IDX_W+1:2];
  assign in_c   = (addr_w >= C_LO) && (addr_w < C_HI);
  assign is_st  = (addr_w == ST_ADDR);
  assign ready  = (state_q == READY);
  assign last_rd = req_i && (addr_w == C_LAST);

  always_comb begin
    status = '0;
    status[16 +: WCNT_W] = wcnt_q;
    status[1] = ovr_q;
    status[0] = ready;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ovr_d   = ovr_q;
    if (req_i && in_c && ready && wcnt_q != WMAX) wcnt_d = wcnt_q + 1'b1;
    if (req_i && is_st) ovr_d = 1'b0;
    // set wins over the clear-on-read above
    if (acc_done && ready && !last_rd) ovr_d = 1'b1;
    case (state_q)
      EMPTY: if (acc_done) state_d = READY;
      READY: if (!acc_done && last_rd) begin
        state_d = EMPTY;
        wcnt_d  = '0;
      end
      default: state_d = EMPTY;
    endcase
    if (acc_done) wcnt_d = '0;
  end

  // Responses always see the pre-edge buffer and state.
  always_comb begin
    rsp_d = rsp_q;
    if (req_i) begin
      if (is_st)            rsp_d = '{rdata: status, err: 1'b0};
      else if (in_c && ready) rsp_d = '{rdata: buf_q[{widx, 5'b0} +: 32], err: 1'b0};
      else                  rsp_d = '{rdata: 32'h0, err: 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      wcnt_q  <= '0;
      ovr_q   <= 1'b0;
      rsp_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ovr_q   <= ovr_d;
      rsp_q   <= rsp_d;
      vld_q   <= req_i;
    end
  end

  // Buffer contents are don't-care out of reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (acc_done) buf_q <= acc_in;
  end

  assign rvalid_o = vld_q;
  assign rdata_o  = rsp_q.rdata;
  assign err_o    = rsp_q.err;
endmodule

// File: tb/tb_acc_result_reader.sv
// Directed bench for acc_result_reader: capture, word reads, status, overrun,
// same-cycle capture/last-read and asynchronous reset.
module tb_acc_result_reader;
  localparam int NB = 1024;
  localparam logic [31:0] ST = 32'd1020;
  localparam logic [31:0] CB = 32'd3072;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          acc_done;
  logic [NB*8-1:0] acc_in;
  logic          req;
  logic [31:0]   addr;
  logic          gnt, rvalid, err;
  logic [31:0]   rdata;

  int checks = 0;
  int failures = 0;

  acc_result_reader dut (
    .clk(clk), .rst_n(rst_n), .acc_done(acc_done), .acc_in(acc_in),
    .req_i(req), .addr_i(addr), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [NB*8-1:0] pat(input int seed);
    logic [NB*8-1:0] p;
    for (int k = 0; k < NB; k++) p[8*k +: 8] = 8'((k + seed) % 256);
    return p;
  endfunction

  function automatic logic [31:0] word_of(input int w, input int seed);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = 8'((4*w + b + seed) % 256);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the next negedge with req low.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic exp_err,
                    input string tag);
    req = 1'b1; addr = a;
    #1 chk({tag, ".gnt"}, 32'(gnt), 32'd1);
    @(negedge clk);
    req = 1'b0;
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, ".rdata"}, rdata, exp);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic capture(input int seed);
    acc_done = 1'b1; acc_in = pat(seed);
    @(negedge clk);
    acc_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; acc_done = 1'b0; acc_in = '0; req = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    rd(ST, 32'h0, 1'b0, "status_reset");
    rd(CB, 32'h0, 1'b1, "c_read_empty");

    capture(0);
    // back-to-back reads
    req = 1'b1; addr = CB;
    @(negedge clk);
    addr = CB + 4;
    chk("b2b0.rvalid", 32'(rvalid), 32'd1);
    chk("b2b0.rdata", rdata, 32'h0302_0100);
    @(negedge clk);
    req = 1'b0;
    chk("b2b1.rvalid", 32'(rvalid), 32'd1);
    chk("b2b1.rdata", rdata, 32'h0706_0504);
    rd(ST, 32'h0002_0001, 1'b0, "status_two");
    @(negedge clk);
    chk("idle.rvalid", 32'(rvalid), 32'd0);
    chk("idle.hold", rdata, 32'h0002_0001);
    rd(CB + 7, 32'h0706_0504, 1'b0, "unaligned");

    for (int w = 0; w < NB/4; w++) rd(CB + 32'(4*w), word_of(w, 0), 1'b0, "sweep");
    chk("last_word", rdata, 32'hFFFE_FDFC);
    rd(ST, 32'h0, 1'b0, "status_drained");
    rd(CB, 32'h0, 1'b1, "read_after_drain");

    capture(0);
    for (int w = 0; w < 10; w++) rd(CB + 32'(4*w), word_of(w, 0), 1'b0, "ten");
    capture(5);
    rd(ST, 32'h0000_0003, 1'b0, "status_ovr");
    rd(ST, 32'h0000_0001, 1'b0, "status_ovr_cleared");

    // last-word read granted in the same cycle as a new capture
    req = 1'b1; addr = CB + 32'd1020; acc_done = 1'b1; acc_in = pat(9);
    @(negedge clk);
    req = 1'b0; acc_done = 1'b0;
    chk("race.rvalid", 32'(rvalid), 32'd1);
    chk("race.old_data", rdata, word_of(255, 5));
    chk("race.err", 32'(err), 32'd0);
    rd(ST, 32'h0000_0001, 1'b0, "race_status");
    rd(CB, word_of(0, 9), 1'b0, "race_new_data");

    rd(32'd4096, 32'h0, 1'b1, "oob_4096");
    rd(CB - 1, 32'h0, 1'b1, "oob_below");
    rd(32'd1024, 32'h0, 1'b1, "oob_1024");

    // reset with a response in flight
    req = 1'b1; addr = CB + 4;
    @(posedge clk);
    #1 chk("inflight.rvalid", 32'(rvalid), 32'd1);
    rst_n = 1'b0;
    #1 chk("async_rst.rvalid", 32'(rvalid), 32'd0);
    chk("async_rst.rdata", rdata, 32'h0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(ST, 32'h0, 1'b0, "status_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acc_result_reader.md
# acc_result_reader

Read-side responder for the matrix accelerator: captures the 1024-byte result matrix C when the accelerator signals completion and serves it to the core as 32-bit words over a req/gnt/rvalid data-bus read port. It also exposes a status word. It complements the write path that loads matrices A and B, and sits between the core data bus and `top_acc`'s `acc_out`.

## Interface
- `N_BYTES`, 1024: result matrix size in bytes; a multiple of 4.
- `BASE_ADDR`, 3072: byte address of C byte 0; the region is [BASE_ADDR, BASE_ADDR+N_BYTES).
- `STATUS_ADDR`, 1020: byte address of the status word.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `acc_done`  in  1: one-cycle pulse from the accelerator; `acc_in` is valid in that cycle.
- `acc_in`  in  N_BYTES×8: packed result bytes; byte k is at bits [8k+7:8k].
- `req_i`  in  1: read request from the core.
- `addr_i`  in  32: byte address; bits [1:0] are ignored.
- `gnt_o`  out  1: request accepted.
- `rvalid_o`  out  1: response valid.
- `rdata_o`  out  32: read data.
- `err_o`  out  1: response error; qualified by `rvalid_o`.

## Operation
- Internal buffer: N_BYTES bytes, loaded in full in the cycle `acc_done`=1.
- FSM has two states:
  - EMPTY (reset state).
  - READY.
- Transitions:
  - EMPTY→READY on `acc_done`.
  - READY→EMPTY on a granted read of the last word (BASE_ADDR+N_BYTES−4) with no `acc_done` in the same cycle.
  - READY→READY on `acc_done`: buffer is overwritten.
- Word counter `wcnt`, 9 bits for the defaults (log2(N_BYTES/4)+1):
  - Increments on every granted C-region read in READY, saturating at N_BYTES/4.
  - Cleared on `acc_done` and on READY→EMPTY.
- Overrun sticky flag `ovr`:
  - Set when `acc_done`=1 in READY, unless the same cycle grants the last-word read.
  - Cleared by a granted status read, unless it is set again in that same cycle (set wins).
- Status word: bit0 = READY, bit1 = `ovr`, bits[15:8] = 0, bits[24:16] = `wcnt`, all other bits 0.
- C word read at address a, with w = (a−BASE_ADDR)>>2: `rdata_o` = {byte 4w+3, 4w+2, 4w+1, 4w} (little-endian).
- Error responses (`rdata_o`=0, `err_o`=1):
  - C-region read while in EMPTY.
  - Any address outside the C region and STATUS_ADDR.
- Read data is taken from the buffer contents before any same-cycle capture. A response always reflects the pre-edge buffer and state.

## Timing
- `gnt_o` = `req_i`, combinational. There are no wait states, and every request is granted in its cycle.
- Response latency is 1: `rvalid_o`=1 in the cycle after the grant, together with `rdata_o` and `err_o`.
- `rvalid_o` is high for exactly one cycle per grant, so back-to-back requests give back-to-back responses.
- `rdata_o` and `err_o` hold their last value when `rvalid_o`=0.
- Reset values:
  - `rvalid_o`=0, `rdata_o`=0, `err_o`=0.
  - State EMPTY, `wcnt`=0, `ovr`=0.
  - Buffer contents are don't-care.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronously). A response in flight is dropped, and `rvalid_o` goes low.
- `acc_done` is sampled only on the clock edge; a pulse longer than one cycle re-captures on every high cycle.

## Test plan
- Reset, then read STATUS_ADDR → response at cycle+1 with `rdata_o`=0x0000_0000, `err_o`=0.
- `acc_done` with byte k = k mod 256, then read 3072 and 3076 back-to-back → 0x0302_0100, then 0x0706_0504, on consecutive cycles. Reading status then gives 0x0002_0001.
- Read all 256 words in order → the last word is 0xFFFE_FDFC. Status afterwards is 0x0000_0000, and a further read of 3072 gives `err_o`=1 with `rdata_o`=0.
- `acc_done`, read 10 words, then a second `acc_done` → status 0x0000_0003. Reading status again gives 0x0000_0001, showing `ovr` cleared on read.
- Grant a last-word read in the same cycle as `acc_done` → the response carries the old data, state stays READY, `wcnt`=0, `ovr`=0.
- Read address 4096 → `err_o`=1. Drop `rst_n` mid-stream → `rvalid_o` goes to 0 immediately, and the status read after reset is 0.
